multicycle_controller: RTL

Moore/Mealy FSM that sequences the shared single-ALU, single-memory multicycle MIPS datapath through fetch, decode, execute, memory and write-back steps, one instruction at a time. It sits beside the datapath, reads the opcode from the instruction register and the ALU zero flag, and drives every mux select, register enable and memory strobe. Memory has variable latency: the FSM holds a request until `mem_ready`.

---
 rtl/multicycle_controller.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for the shared single-ALU, single-memory multicycle MIPS
// datapath. The FSM runs one instruction at a time through fetch, decode,
// execute, memory and write-back. It drives every mux select, register
// enable and memory strobe of the datapath. Memory latency varies, so a
// request is held until mem_ready.
//
// Ports
//   clk        in   single clock; all state changes on the rising edge
//   rst        in   synchronous, active-high reset; forces every output to 0
//   opcode     in   instr[31:26] from the IR, valid from DECODE onward
//   zero       in   ALU zero flag (used by BRANCH)
//   mem_ready  in   memory finishes the current read/write this cycle
//   pc_en      out  PC write enable (Mealy in FETCH and BRANCH)
//   ir_en      out  IR write enable (Mealy in FETCH)
//   i_or_d     out  memory address select: 0 = PC, 1 = ALUOut
//   mem_read   out  memory read request
//   mem_write  out  memory write request
//   reg_write  out  register file write enable
//   reg_dst    out  destination select: 0 = rt, 1 = rd
//   mem_2_reg  out  write-back select: 0 = ALUOut, 1 = MDR
//   alu_src_a  out  ALU A select: 0 = PC, 1 = register A
//   alu_src_b  out  ALU B select: 0 = B, 1 = 4, 2 = simm, 3 = simm<<2
//   alu_op     out  0 = add, 1 = sub, 2 = R-type funct decode
//   pc_source  out  0 = ALU result, 1 = ALUOut, 2 = jump target
//   retire     out  one-cycle pulse in the last cycle of each instruction
//   illegal_op out  high while parked in HALT
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_2_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       retire,
    output logic       illegal_op
);

    // ---------------------------------------------------------------------
    // Opcodes the controller understands
    // ---------------------------------------------------------------------
    localparam logic [5:0] ALU_R      = 6'h00;
    localparam logic [5:0] JUMP       = 6'h02;
    localparam logic [5:0] BRANCH_EQ  = 6'h04;
    localparam logic [5:0] ADDI       = 6'h08;
    localparam logic [5:0] LOAD_WORD  = 6'h23;
    localparam logic [5:0] STORE_WORD = 6'h2B;

    // ---------------------------------------------------------------------
    // State encoding
    // ---------------------------------------------------------------------
    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXECUTE   = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_ADDI_EXEC = 4'd8;
    localparam logic [3:0] S_ADDI_WB   = 4'd9;
    localparam logic [3:0] S_BRANCH    = 4'd10;
    localparam logic [3:0] S_JUMP      = 4'd11;
    localparam logic [3:0] S_HALT      = 4'd12;

    // ALU operand / operation encodings, named for readability below
    localparam logic [1:0] SRC_B_REG     = 2'd0;
    localparam logic [1:0] SRC_B_FOUR    = 2'd1;
    localparam logic [1:0] SRC_B_IMM     = 2'd2;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'd3;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    logic [3:0] state_q;
    logic [3:0] state_d;

    // Opcode class flags, shared by DECODE and MEM_ADDR
    logic is_r_type;
    logic is_addi;
    logic is_beq;
    logic is_jump;
    logic is_lw;
    logic is_sw;

    assign is_r_type = (opcode == ALU_R);
    assign is_addi   = (opcode == ADDI);
    assign is_beq    = (opcode == BRANCH_EQ);
    assign is_jump   = (opcode == JUMP);
    assign is_lw     = (opcode == LOAD_WORD);
    assign is_sw     = (opcode == STORE_WORD);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples the pre-edge value; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                if (is_r_type) begin
                    state_d = S_EXECUTE;
                end else if (is_addi) begin
                    state_d = S_ADDI_EXEC;
                end else if (is_beq) begin
                    state_d = S_BRANCH;
                end else if (is_jump) begin
                    state_d = S_JUMP;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM_ADDR;
                end else begin
                    state_d = S_HALT;
                end
            end

            // Opcode is looked at again to split loads from stores; anything
            // else arriving here means the IR changed underneath us, so park.
            S_MEM_ADDR: begin
                if (is_lw) begin
                    state_d = S_MEM_READ;
                end else if (is_sw) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_HALT;
                end
            end

            S_MEM_READ: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end

            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end

            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;

            S_MEM_WB,
            S_R_WB,
            S_ADDI_WB,
            S_BRANCH,
            S_JUMP:      state_d = S_FETCH;

            // HALT is sticky; only rst leaves it.
            S_HALT:      state_d = S_HALT;

            // Unused encodings are treated as a fault.
            default:     state_d = S_HALT;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output decode
    //   Moore outputs depend on state only. ir_en, pc_en and retire also
    //   follow mem_ready / zero in the same cycle. While rst is high every
    //   output is held at 0, so an in-flight request is dropped at once.
    // ---------------------------------------------------------------------
    always_comb begin
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_2_reg  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_ADD;
        pc_source  = PC_ALU;
        retire     = 1'b0;
        illegal_op = 1'b0;

        if (!rst) begin
            case (state_q)
                // Read the instruction at PC and compute PC+4 in parallel.
                // Both IR and PC update only on the cycle memory answers.
                S_FETCH: begin
                    mem_read  = 1'b1;
                    i_or_d    = 1'b0;
                    alu_src_a = 1'b0;
                    alu_src_b = SRC_B_FOUR;
                    alu_op    = ALU_ADD;
                    pc_source = PC_ALU;
                    ir_en     = mem_ready;
                    pc_en     = mem_ready;
                end

                // Compute the branch target into ALUOut speculatively.
                S_DECODE: begin
                    alu_src_a = 1'b0;
                    alu_src_b = SRC_B_IMM_SH2;
                    alu_op    = ALU_ADD;
                end

                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ADD;
                end

                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end

                S_MEM_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b0;
                    mem_2_reg = 1'b1;
                    retire    = 1'b1;
                end

                // A store ends in the cycle its write completes.
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                end

                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_REG;
                    alu_op    = ALU_FUNCT;
                end

                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    mem_2_reg = 1'b0;
                    retire    = 1'b1;
                end

                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                    alu_op    = ALU_ADD;
                end

                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b0;
                    mem_2_reg = 1'b0;
                    retire    = 1'b1;
                end

                // Compare A-B; the target waiting in ALUOut is taken only
                // when the subtraction is zero.
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_REG;
                    alu_op    = ALU_SUB;
                    pc_source = PC_ALUOUT;
                    pc_en     = zero;
                    retire    = 1'b1;
                end

                S_JUMP: begin
                    pc_source = PC_JUMP;
                    pc_en     = 1'b1;
                    retire    = 1'b1;
                end

                S_HALT: begin
                    illegal_op = 1'b1;
                end

                default: begin
                    illegal_op = 1'b0;
                end
            endcase
        end
    end

endmodule
